// File: rtl/sd_spi_engine_if.sv
// Register bus between a host and sd_spi_engine: 3-bit select, one-cycle strobes, 16-bit data.
interface sd_spi_engine_if;
  logic [2:0]  BUS_ADDR;
  logic        BUS_WR;
  logic        BUS_RD;
  logic [15:0] BUS_WDATA;
  logic [15:0] BUS_RDATA;

  modport master (output BUS_ADDR, BUS_WR, BUS_RD, BUS_WDATA, input BUS_RDATA);
  modport slave  (input BUS_ADDR, BUS_WR, BUS_RD, BUS_WDATA, output BUS_RDATA);
endinterface

// File: rtl/sd_spi_engine.sv
// SD-card SPI mode-0 byte/burst engine with RX FIFO; SD_SPI_CRC16_EN adds a burst CRC16 at reg 4.
// Latency: BUSY one cycle after the CTRL strobe, byte = 16 half-periods of (DIV+1) cycles.
// Backpressure: a burst stalls at a byte boundary while the RX FIFO is full, resumes after a pop.
module sd_spi_engine #(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_W    = 10
) (
  input  logic           CLOCK_24,
  input  logic           nRESET,
  sd_spi_engine_if.slave bus,
  output logic           SPI_CLK,
  output logic           SPI_MOSI,
  input  logic           SPI_MISO,
  output logic           SPI_CS,
  output logic           BUSY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] KEY_LOCK   = 16'h57F1;
  localparam logic [15:0] KEY_UNLOCK = 16'h741C;
  localparam logic [AW:0] LVL_FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LVL_ALMOST = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STALL} state_t;
  state_t state;

  logic               lock;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] burst_rem;
  logic               burst_mode;
  logic [7:0]         tx_sr;
  logic [7:0]         rx_sr;
  logic [7:0]         rxlast;
  logic [2:0]         bit_cnt;
`ifdef SD_SPI_CRC16_EN
  logic [15:0]        crc;
`endif

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [7:0]    level8;

  logic cfg_ok, wr_ctrl, start_single, start_burst;
  logic half_end, byte_end, push, pop, full_after;

  assign fifo_full  = (level == LVL_FULL);
  assign fifo_empty = (level == '0);
  assign fifo_head  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign level8     = 8'(level);

  assign cfg_ok       = !lock && !BUSY;
  assign wr_ctrl      = bus.BUS_WR && (bus.BUS_ADDR == 3'd1) && cfg_ok;
  assign start_single = wr_ctrl && bus.BUS_WDATA[8];
  assign start_burst  = wr_ctrl && !bus.BUS_WDATA[8] && bus.BUS_WDATA[10] && (burst_q != '0);

  assign half_end   = (state == SHIFT) && (div_cnt == div_q);
  assign byte_end   = half_end && SPI_CLK && (bit_cnt == 3'd7);
  assign push       = byte_end && burst_mode;
  assign pop        = bus.BUS_RD && (bus.BUS_ADDR == 3'd3) && !fifo_empty;
  // push never coincides with a full FIFO, so only a same-cycle pop can keep room
  assign full_after = (level == LVL_ALMOST) && !pop;

  always_comb begin
    bus.BUS_RDATA = '0;
    case (bus.BUS_ADDR)
      3'd0: bus.BUS_RDATA[0] = lock;
      3'd1: bus.BUS_RDATA = {fifo_full, fifo_empty, 5'b0, BUSY, rxlast};
      3'd2: bus.BUS_RDATA[DIV_W-1:0] = div_q;
      3'd3: bus.BUS_RDATA = {level8, fifo_head};
`ifdef SD_SPI_CRC16_EN
      3'd4: bus.BUS_RDATA = crc;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_24) begin
    if (push)
      fifo_mem[wr_ptr] <= rx_sr;
  end

  always_ff @(posedge CLOCK_24 or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_24 or negedge nRESET) begin
    if (!nRESET) begin
      state      <= IDLE;
      lock       <= 1'b1;
      SPI_CS     <= 1'b1;
      SPI_CLK    <= 1'b0;
      SPI_MOSI   <= 1'b1;
      BUSY       <= 1'b0;
      div_q      <= '1;
      div_cnt    <= '0;
      burst_q    <= '0;
      burst_rem  <= '0;
      burst_mode <= 1'b0;
      tx_sr      <= 8'hFF;
      rx_sr      <= 8'h00;
      rxlast     <= 8'h00;
      bit_cnt    <= 3'd0;
`ifdef SD_SPI_CRC16_EN
      crc        <= 16'h0000;
`endif
    end else begin
      if (bus.BUS_WR && (bus.BUS_ADDR == 3'd0)) begin
        if (bus.BUS_WDATA == KEY_LOCK)
          lock <= 1'b1;
        else if (bus.BUS_WDATA == KEY_UNLOCK)
          lock <= 1'b0;
      end
      if (bus.BUS_WR && cfg_ok) begin
        case (bus.BUS_ADDR)
          3'd1:    SPI_CS  <= bus.BUS_WDATA[9];
          3'd2:    div_q   <= bus.BUS_WDATA[DIV_W-1:0];
          3'd3:    burst_q <= bus.BUS_WDATA[BURST_W-1:0];
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= 3'd0;
          if (start_single) begin
            state      <= SHIFT;
            BUSY       <= 1'b1;
            burst_mode <= 1'b0;
            tx_sr      <= bus.BUS_WDATA[7:0];
            SPI_MOSI   <= bus.BUS_WDATA[7];
          end else if (start_burst) begin
            // a FIFO left full by an earlier burst must drain before any byte is clocked
            state      <= fifo_full ? STALL : SHIFT;
            BUSY       <= 1'b1;
            burst_mode <= 1'b1;
            burst_rem  <= burst_q;
            tx_sr      <= 8'hFF;
            SPI_MOSI   <= 1'b1;
`ifdef SD_SPI_CRC16_EN
            crc        <= 16'h0000;
`endif
          end
        end

        SHIFT: begin
          if (!half_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!SPI_CLK) begin
              SPI_CLK <= 1'b1;
              rx_sr   <= {rx_sr[6:0], SPI_MISO};
`ifdef SD_SPI_CRC16_EN
              if (burst_mode)
                crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ SPI_MISO) ? 16'h1021 : 16'h0000);
`endif
            end else begin
              SPI_CLK <= 1'b0;
              if (!byte_end) begin
                bit_cnt  <= bit_cnt + 3'd1;
                tx_sr    <= {tx_sr[6:0], 1'b1};
                SPI_MOSI <= tx_sr[6];
              end else begin
                rxlast   <= rx_sr;
                bit_cnt  <= 3'd0;
                tx_sr    <= 8'hFF;
                SPI_MOSI <= 1'b1;
                if (!burst_mode || (burst_rem == BURST_W'(1))) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
                end else begin
                  burst_rem <= burst_rem - BURST_W'(1);
                  if (full_after)
                    state <= STALL;
                end
              end
            end
          end
        end

        STALL: begin
          SPI_CLK  <= 1'b0;
          SPI_MOSI <= 1'b1;
          div_cnt  <= '0;
          bit_cnt  <= 3'd0;
          if (!fifo_full)
            state <= SHIFT;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_spi_engine.sv
// Scoreboard bench for sd_spi_engine: expected bytes/bits queued at stimulus, popped as the DUT delivers them.
module tb_sd_spi_engine;
  logic CLOCK_24 = 1'b0;
  logic nRESET;
  logic SPI_CLK, SPI_MOSI, SPI_MISO, SPI_CS, BUSY;
  logic miso_loop = 1'b1;
  logic miso_const = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [7:0] exp_q [$];
  logic       exp_bits [$];
  logic       mosi_cap [$];

  sd_spi_engine_if bus_if ();

  sd_spi_engine #(.DIV_W(8), .FIFO_DEPTH(16), .BURST_W(10)) dut (
    .CLOCK_24 (CLOCK_24),
    .nRESET   (nRESET),
    .bus      (bus_if),
    .SPI_CLK  (SPI_CLK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .SPI_CS   (SPI_CS),
    .BUSY     (BUSY)
  );

  always #5 CLOCK_24 = ~CLOCK_24;
  assign SPI_MISO = miso_loop ? SPI_MOSI : miso_const;
  always @(posedge SPI_CLK) mosi_cap.push_back(SPI_MOSI);

  task automatic tick();
    @(posedge CLOCK_24);
    #1;
  endtask

  task automatic apply_reset();
    bus_if.BUS_WR = 1'b0; bus_if.BUS_RD = 1'b0;
    bus_if.BUS_ADDR = 3'd0; bus_if.BUS_WDATA = 16'h0000;
    miso_loop = 1'b1; miso_const = 1'b1;
    exp_q.delete(); exp_bits.delete();
    nRESET = 1'b0;
    repeat (3) @(posedge CLOCK_24);
    #1 nRESET = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.BUS_ADDR = a; bus_if.BUS_WDATA = d; bus_if.BUS_WR = 1'b1;
    @(posedge CLOCK_24);
    #1 bus_if.BUS_WR = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    bus_if.BUS_ADDR = a;
    @(negedge CLOCK_24);
    d = bus_if.BUS_RDATA;
  endtask

  task automatic pop(output logic [15:0] d);
    bus_if.BUS_ADDR = 3'd3;
    @(negedge CLOCK_24);
    d = bus_if.BUS_RDATA;
    bus_if.BUS_RD = 1'b1;
    @(posedge CLOCK_24);
    #1 bus_if.BUS_RD = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [15:0] exp_reg [8];
    apply_reset();
    exp_reg = '{16'h0001, 16'h4000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    n_checks++; if ({SPI_CS, SPI_CLK, SPI_MOSI, BUSY} !== 4'b1010) begin n_fail++;
      $display("FAIL reset_pins: cs/clk/mosi/busy got %b want 1010", {SPI_CS, SPI_CLK, SPI_MOSI, BUSY}); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      n_checks++; if (d !== exp_reg[a]) begin n_fail++;
        $display("FAIL reset_reg%0d: got %h want %h", a, d, exp_reg[a]); end
    end
  endtask

  task automatic test_locked();
    logic [15:0] d;
    int base;
    apply_reset();
    base = mosi_cap.size();
    wr(3'd0, 16'h1234);
    wr(3'd1, 16'h0155);
    wr(3'd2, 16'h0003);
    wr(3'd5, 16'h741C);
    repeat (50) tick();
    n_checks++; if (mosi_cap.size() != base) begin n_fail++;
      $display("FAIL locked_no_clk: rising edges got %0d want 0", mosi_cap.size() - base); end
    n_checks++; if ({BUSY, SPI_CS} !== 2'b01) begin n_fail++;
      $display("FAIL locked_busy_cs: got %b want 01", {BUSY, SPI_CS}); end
    rd(3'd2, d);
    n_checks++; if (d !== 16'h00FF) begin n_fail++; $display("FAIL locked_div: got %h want 00ff", d); end
    rd(3'd0, d);
    n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL locked_key: got %h want 0001", d); end
  endtask

  task automatic test_loopback();
    logic [15:0] d;
    logic [7:0]  tx;
    int base, cnt;
    apply_reset();
    wr(3'd0, 16'h741C);
    wr(3'd2, 16'h0000);
    tx = 8'hA5;
    for (int i = 7; i >= 0; i--) exp_bits.push_back(tx[i]);
    exp_q.push_back(tx);
    base = mosi_cap.size();
    wr(3'd1, 16'h01A5);
    n_checks++; if ({SPI_MOSI, SPI_CS} !== 2'b10) begin n_fail++;
      $display("FAIL lb_start: mosi/cs got %b want 10", {SPI_MOSI, SPI_CS}); end
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 200) begin cnt++; tick(); end
    n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL lb_busy_cycles: got %0d want 16", cnt); end
    n_checks++; if (mosi_cap.size() - base != 8) begin n_fail++;
      $display("FAIL lb_edges: got %0d want 8", mosi_cap.size() - base); end
    for (int i = 0; i < 8 && exp_bits.size() > 0; i++) begin
      logic eb;
      eb = exp_bits.pop_front();
      n_checks++; if (mosi_cap[base + i] !== eb) begin n_fail++;
        $display("FAIL lb_mosi_bit%0d: got %b want %b", i, mosi_cap[base + i], eb); end
    end
    rd(3'd1, d);
    n_checks++; if (d !== {8'h40, exp_q.pop_front()}) begin n_fail++;
      $display("FAIL lb_ctrl: got %h want 40a5", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [7:0]  tx [2];
    int cnt;
    apply_reset();
    wr(3'd0, 16'h741C);
    wr(3'd2, 16'h0003);
    tx = '{8'h3C, 8'hC3};
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(tx[k]);
      wr(3'd1, {8'h01, tx[k]});
      wr(3'd2, 16'h0007);
      wr(3'd1, 16'h0355);
      cnt = 0;
      while (BUSY === 1'b1 && cnt < 500) begin cnt++; tick(); end
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout%0d: busy got %b want 0", k, BUSY); end
      rd(3'd1, d);
      n_checks++; if (d[7:0] !== exp_q.pop_front()) begin n_fail++;
        $display("FAIL b2b_rxlast%0d: got %h want %h", k, d[7:0], tx[k]); end
      rd(3'd2, d);
      n_checks++; if (d !== 16'h0003) begin n_fail++; $display("FAIL b2b_div%0d: got %h want 0003", k, d); end
      n_checks++; if (SPI_CS !== 1'b0) begin n_fail++; $display("FAIL b2b_cs%0d: got %b want 0", k, SPI_CS); end
    end
    wr(3'd0, 16'h57F1);
    wr(3'd2, 16'h0009);
    rd(3'd2, d);
    n_checks++; if (d !== 16'h0003) begin n_fail++; $display("FAIL relock_div: got %h want 0003", d); end
  endtask

  task automatic test_burst_stall();
    logic [15:0] d;
    int base, cnt, clk_hi;
    apply_reset();
    wr(3'd0, 16'h741C);
    wr(3'd2, 16'h0003);
    wr(3'd3, 16'd20);
    miso_loop = 1'b0; miso_const = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(8'hFF);
    base = mosi_cap.size();
    wr(3'd1, 16'h0400);
    cnt = 0;
    d = 16'h0000;
    while (d[15] !== 1'b1 && cnt < 5000) begin cnt++; rd(3'd1, d); end
    n_checks++; if (d[15] !== 1'b1) begin n_fail++; $display("FAIL burst_full: ctrl got %h want bit15 set", d); end
    clk_hi = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (SPI_CLK !== 1'b0) clk_hi++; end
    n_checks++; if (clk_hi != 0) begin n_fail++; $display("FAIL stall_clk: high samples got %0d want 0", clk_hi); end
    n_checks++; if ({BUSY, SPI_MOSI} !== 2'b11) begin n_fail++;
      $display("FAIL stall_busy_mosi: got %b want 11", {BUSY, SPI_MOSI}); end
    n_checks++; if (mosi_cap.size() - base != 128) begin n_fail++;
      $display("FAIL stall_edges: got %0d want 128", mosi_cap.size() - base); end
    rd(3'd3, d);
    n_checks++; if (d !== 16'h10FF) begin n_fail++; $display("FAIL stall_level: got %h want 10ff", d); end
    for (int i = 0; i < 4; i++) begin
      pop(d);
      n_checks++; if (d[7:0] !== exp_q.pop_front()) begin n_fail++; $display("FAIL pop4_head%0d: got %h want ff", i, d[7:0]); end
    end
    cnt = 0;
    while (BUSY === 1'b1 && cnt < 2000) begin cnt++; tick(); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL burst_done: busy got %b want 0", BUSY); end
    n_checks++; if (mosi_cap.size() - base != 160) begin n_fail++;
      $display("FAIL burst_edges: got %0d want 160", mosi_cap.size() - base); end
    rd(3'd1, d);
    n_checks++; if (d !== 16'h80FF) begin n_fail++; $display("FAIL burst_ctrl: got %h want 80ff", d); end
    for (int i = 0; i < 16; i++) begin
      pop(d);
      n_checks++; if (d !== {8'(16 - i), exp_q.pop_front()}) begin n_fail++;
        $display("FAIL drain%0d: got %h want %h", i, d, {8'(16 - i), 8'hFF}); end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_sb_left: got %0d want 0", exp_q.size()); end
    rd(3'd1, d);
    n_checks++; if (d !== 16'h40FF) begin n_fail++; $display("FAIL drained_ctrl: got %h want 40ff", d); end
  endtask

  task automatic test_empty_pop();
    logic [15:0] d;
    int base;
    apply_reset();
    pop(d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL empty_pop_head: got %h want 0000", d); end
    rd(3'd3, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL empty_pop_level: got %h want 0000", d); end
    rd(3'd1, d);
    n_checks++; if (d !== 16'h4000) begin n_fail++; $display("FAIL empty_pop_ctrl: got %h want 4000", d); end
    wr(3'd0, 16'h741C);
    base = mosi_cap.size();
    wr(3'd1, 16'h0400);
    repeat (20) tick();
    n_checks++; if (BUSY !== 1'b0 || mosi_cap.size() != base) begin n_fail++;
      $display("FAIL burst_zero: busy %b edges %0d want 0/0", BUSY, mosi_cap.size() - base); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int base, cnt;
    apply_reset();
    wr(3'd0, 16'h741C);
    wr(3'd2, 16'h0001);
    wr(3'd3, 16'd5);
    miso_loop = 1'b0; miso_const = 1'b1;
    base = mosi_cap.size();
    wr(3'd1, 16'h0400);
    cnt = 0;
    while (mosi_cap.size() - base < 12 && cnt < 2000) begin cnt++; tick(); end
    n_checks++; if (mosi_cap.size() - base != 12) begin n_fail++;
      $display("FAIL mid_edges: got %0d want 12", mosi_cap.size() - base); end
    rd(3'd3, d);
    n_checks++; if (d !== 16'h01FF) begin n_fail++; $display("FAIL mid_level: got %h want 01ff", d); end
    #2 nRESET = 1'b0;
    #1;
    n_checks++; if ({SPI_CS, SPI_CLK, SPI_MOSI, BUSY} !== 4'b1010) begin n_fail++;
      $display("FAIL mid_reset_pins: got %b want 1010", {SPI_CS, SPI_CLK, SPI_MOSI, BUSY}); end
    n_checks++; if (bus_if.BUS_RDATA !== 16'h0000) begin n_fail++;
      $display("FAIL mid_reset_fifo: got %h want 0000", bus_if.BUS_RDATA); end
    bus_if.BUS_ADDR = 3'd1;
    #1;
    n_checks++; if (bus_if.BUS_RDATA !== 16'h4000) begin n_fail++;
      $display("FAIL mid_reset_ctrl: got %h want 4000", bus_if.BUS_RDATA); end
    @(posedge CLOCK_24);
    #1 nRESET = 1'b1;
    repeat (40) tick();
    rd(3'd3, d);
    n_checks++; if (d !== 16'h0000 || BUSY !== 1'b0) begin n_fail++;
      $display("FAIL mid_after: reg3 %h busy %b want 0000/0", d, BUSY); end
  endtask

`ifdef SD_SPI_CRC16_EN
  task automatic test_crc();
    logic [15:0] d;
    int pops, cnt;
    apply_reset();
    wr(3'd0, 16'h741C);
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'd512);
    miso_loop = 1'b0; miso_const = 1'b1;
    wr(3'd1, 16'h0400);
    pops = 0;
    cnt = 0;
    d = 16'h0100;
    while ((BUSY === 1'b1 || d[15:8] != 8'h00) && cnt < 40000) begin
      cnt++;
      rd(3'd3, d);
      if (d[15:8] != 8'h00) begin pop(d); pops++; end
    end
    n_checks++; if (pops != 512) begin n_fail++; $display("FAIL crc_pops: got %0d want 512", pops); end
    rd(3'd4, d);
    n_checks++; if (d !== 16'h7FA1) begin n_fail++; $display("FAIL crc_value: got %h want 7fa1", d); end
  endtask
`endif

  initial begin
    nRESET = 1'b0;
    bus_if.BUS_WR = 1'b0; bus_if.BUS_RD = 1'b0;
    bus_if.BUS_ADDR = 3'd0; bus_if.BUS_WDATA = 16'h0000;
    test_reset();
    test_locked();
    test_loopback();
    test_back_to_back();
    test_burst_stall();
    test_empty_pop();
    test_reset_mid();
`ifdef SD_SPI_CRC16_EN
    test_crc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
